// File: rtl/exception_commit_unit_pkg.sv
// Shared definitions for exception_commit_unit.
// Contents: exception codes and subcodes, bit positions inside wb_ex_flags,
// and the commit FSM state encoding.
package exception_commit_unit_pkg;

  // Bit positions inside wb_ex_flags
  localparam int EXF_ADEF = 0;
  localparam int EXF_INE  = 1;
  localparam int EXF_SYS  = 2;
  localparam int EXF_BRK  = 3;
  localparam int EXF_ALE  = 4;
  localparam int EXF_ADEM = 5;

  // Exception codes written to ESTAT.Ecode
  localparam logic [5:0] ECODE_INT = 6'h0;
  localparam logic [5:0] ECODE_ADE = 6'h8;
  localparam logic [5:0] ECODE_ALE = 6'h9;
  localparam logic [5:0] ECODE_SYS = 6'hB;
  localparam logic [5:0] ECODE_BRK = 6'hC;
  localparam logic [5:0] ECODE_INE = 6'hD;

  // Subcodes distinguishing the two address-error flavours
  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/exception_commit_unit_ex_priority_enc.sv
// ex_priority_enc: purely combinational priority encoder for the committing
// instruction. Fixed priority, highest first:
//   INT > ADEF > INE > SYS > BRK > ALE > ADEM
// Ports:
//   has_int     in   pending interrupt from the CSR block
//   wb_ex_flags in   per-instruction exception flags (see EXF_* indices)
//   any_ex      out  an interrupt or at least one exception flag is present
//   ecode       out  exception code of the winning cause
//   esubcode    out  subcode of the winning cause
module ex_priority_enc
  import exception_commit_unit_pkg::*;
(
  input  logic       has_int,
  input  logic [5:0] wb_ex_flags,
  output logic       any_ex,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  always_comb begin
    any_ex   = has_int || (|wb_ex_flags);
    ecode    = ECODE_INT;
    esubcode = ESUBCODE_ADEF;
    if (has_int) begin
      ecode = ECODE_INT;
    end else if (wb_ex_flags[EXF_ADEF]) begin
      ecode = ECODE_ADE;
    end else if (wb_ex_flags[EXF_INE]) begin
      ecode = ECODE_INE;
    end else if (wb_ex_flags[EXF_SYS]) begin
      ecode = ECODE_SYS;
    end else if (wb_ex_flags[EXF_BRK]) begin
      ecode = ECODE_BRK;
    end else if (wb_ex_flags[EXF_ALE]) begin
      ecode = ECODE_ALE;
    end else if (wb_ex_flags[EXF_ADEM]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEM;
    end
  end

endmodule

// File: rtl/exception_commit_unit.sv
// exception_commit_unit: single commit point for exceptions, interrupts and
// ERTN, between the WB stage and the CSR block.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wb_valid / wb_ready              WB commit handshake (ready only in IDLE)
//   wb_pc, wb_vaddr, wb_ex_flags,
//   wb_is_ertn, wb_csr_*             committing instruction's attributes
//   has_int, ex_entry, ex_ra         interrupt pending, EENTRY and ERA
//   csr_we/wnum/wmask/wvalue         CSR write, suppressed on exception
//   wb_ex, wb_ecode, wb_esubcode,
//   csr_wb_pc, csr_wb_vaddr,
//   ertn_flush                       exception / ERTN commit to the CSR block
//   flush                            cancel all younger in-flight instructions
//   redirect_valid/pc/ready          fetch redirect handshake
//   retire                           instruction retired normally
//   ex_count                         taken exceptions + interrupts (wrapping)
//
// Redirect handshake: redirect_pc is a valid target whenever redirect_valid
// is high and stays unchanged until the cycle redirect_valid && redirect_ready,
// after which redirect_valid drops and commits resume the following cycle.
module exception_commit_unit
  import exception_commit_unit_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [PC_W-1:0]  wb_pc,
  input  logic [PC_W-1:0]  wb_vaddr,
  input  logic [5:0]       wb_ex_flags,
  input  logic             wb_is_ertn,
  input  logic             wb_csr_we,
  input  logic [13:0]      wb_csr_num,
  input  logic [31:0]      wb_csr_wmask,
  input  logic [31:0]      wb_csr_wvalue,
  input  logic             has_int,
  input  logic [PC_W-1:0]  ex_entry,
  input  logic [PC_W-1:0]  ex_ra,
  output logic             csr_we,
  output logic [13:0]      csr_wnum,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [PC_W-1:0]  csr_wb_pc,
  output logic [PC_W-1:0]  csr_wb_vaddr,
  output logic             ertn_flush,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             retire,
  output logic [CNT_W-1:0] ex_count
);

  state_t state;
  logic   commit;
  logic   any_ex;
  logic   take_ex;

  ex_priority_enc u_prio (
    .has_int     (has_int),
    .wb_ex_flags (wb_ex_flags),
    .any_ex      (any_ex),
    .ecode       (wb_ecode),
    .esubcode    (wb_esubcode)
  );

  assign wb_ready = (state == ST_IDLE);
  assign commit   = wb_valid && wb_ready;
  assign take_ex  = commit && any_ex;

  // CSR-side outputs are combinational so the CSR block samples them on the
  // same edge that commits the instruction.
  assign wb_ex        = take_ex;
  assign csr_wb_pc    = wb_pc;
  assign csr_wb_vaddr = wb_vaddr;
  // ERTN and CSR writes are dropped when the same instruction traps.
  assign ertn_flush   = commit && wb_is_ertn && !take_ex;
  assign csr_we       = commit && wb_csr_we && !take_ex;
  assign csr_wnum     = wb_csr_num;
  assign csr_wmask    = wb_csr_wmask;
  assign csr_wvalue   = wb_csr_wvalue;

  assign retire = commit && !take_ex;
  assign flush  = take_ex || ertn_flush || (state == ST_REDIRECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ex_count       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_ex) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= ex_entry;
            ex_count       <= ex_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (ertn_flush) begin
            // ex_ra is ERA before this commit; ERTN does not change it.
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= ex_ra;
          end
        end
        ST_REDIRECT: begin
          if (redirect_valid && redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_commit_unit.sv
// Directed bench for exception_commit_unit (CNT_W=4 so the counter wrap is
// reachable in a handful of exceptions).
module tb_exception_commit_unit;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam logic [31:0] ENTRY = 32'h1c008000;
  localparam logic [31:0] ERA   = 32'h1c000100;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             wb_valid, wb_ready;
  logic [PC_W-1:0]  wb_pc, wb_vaddr;
  logic [5:0]       wb_ex_flags;
  logic             wb_is_ertn, wb_csr_we;
  logic [13:0]      wb_csr_num;
  logic [31:0]      wb_csr_wmask, wb_csr_wvalue;
  logic             has_int;
  logic [PC_W-1:0]  ex_entry, ex_ra;
  logic             csr_we;
  logic [13:0]      csr_wnum;
  logic [31:0]      csr_wmask, csr_wvalue;
  logic             wb_ex;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic [PC_W-1:0]  csr_wb_pc, csr_wb_vaddr;
  logic             ertn_flush, flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             redirect_ready;
  logic             retire;
  logic [CNT_W-1:0] ex_count;

  exception_commit_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ex_flags(wb_ex_flags),
    .wb_is_ertn(wb_is_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
    .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
    .has_int(has_int), .ex_entry(ex_entry), .ex_ra(ex_ra),
    .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .csr_wb_pc(csr_wb_pc), .csr_wb_vaddr(csr_wb_vaddr), .ertn_flush(ertn_flush),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .retire(retire), .ex_count(ex_count)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    wb_valid = 1'b0; wb_ex_flags = '0; wb_is_ertn = 1'b0; wb_csr_we = 1'b0;
    has_int = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic drive(input logic hi, input logic [5:0] fl, input logic er,
                       input logic cwe, input logic [31:0] pc, input logic [31:0] va);
    wb_valid = 1'b1; has_int = hi; wb_ex_flags = fl; wb_is_ertn = er; wb_csr_we = cwe;
    wb_pc = pc; wb_vaddr = va;
    wb_csr_num = pc[13:0] ^ 14'h0155; wb_csr_wmask = ~pc; wb_csr_wvalue = va ^ 32'h5a5a5a5a;
  endtask

  // vectors: inputs then expected outputs of the commit cycle
  typedef struct {
    logic       has_int;
    logic [5:0] flags;
    logic       ertn;
    logic       cwe;
    logic       ex;
    logic [5:0] ecode;
    logic [8:0] esub;
    logic       o_cwe;
    logic       o_ertn;
    logic       o_ret;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 6'h00, 1'b0, 1'b1,  1'b0, 6'h0, 9'd0, 1'b1, 1'b0, 1'b1}; // plain + csr write
    vecs[1]  = '{1'b1, 6'h12, 1'b0, 1'b1,  1'b1, 6'h0, 9'd0, 1'b0, 1'b0, 1'b0}; // INT beats INE+ALE
    vecs[2]  = '{1'b0, 6'h21, 1'b0, 1'b0,  1'b1, 6'h8, 9'd0, 1'b0, 1'b0, 1'b0}; // ADEF beats ADEM
    vecs[3]  = '{1'b0, 6'h20, 1'b0, 1'b0,  1'b1, 6'h8, 9'd1, 1'b0, 1'b0, 1'b0}; // ADEM alone
    vecs[4]  = '{1'b0, 6'h02, 1'b0, 1'b0,  1'b1, 6'hD, 9'd0, 1'b0, 1'b0, 1'b0}; // INE
    vecs[5]  = '{1'b0, 6'h04, 1'b0, 1'b0,  1'b1, 6'hB, 9'd0, 1'b0, 1'b0, 1'b0}; // SYS
    vecs[6]  = '{1'b0, 6'h08, 1'b0, 1'b0,  1'b1, 6'hC, 9'd0, 1'b0, 1'b0, 1'b0}; // BRK
    vecs[7]  = '{1'b0, 6'h10, 1'b0, 1'b1,  1'b1, 6'h9, 9'd0, 1'b0, 1'b0, 1'b0}; // ALE kills csr write
    vecs[8]  = '{1'b0, 6'h0C, 1'b0, 1'b0,  1'b1, 6'hB, 9'd0, 1'b0, 1'b0, 1'b0}; // SYS beats BRK
    vecs[9]  = '{1'b0, 6'h30, 1'b0, 1'b0,  1'b1, 6'h9, 9'd0, 1'b0, 1'b0, 1'b0}; // ALE beats ADEM
    vecs[10] = '{1'b0, 6'h00, 1'b1, 1'b0,  1'b0, 6'h0, 9'd0, 1'b0, 1'b1, 1'b1}; // ERTN
    vecs[11] = '{1'b1, 6'h00, 1'b1, 1'b0,  1'b1, 6'h0, 9'd0, 1'b0, 1'b0, 1'b0}; // ERTN loses to INT
    vecs[12] = '{1'b0, 6'h02, 1'b1, 1'b1,  1'b1, 6'hD, 9'd0, 1'b0, 1'b0, 1'b0}; // ERTN+csr lose to INE
  end

  initial begin
    logic [31:0] pc, va, rpc;
    idle_inputs();
    wb_pc = '0; wb_vaddr = '0; wb_csr_num = '0; wb_csr_wmask = '0; wb_csr_wvalue = '0;
    ex_entry = ENTRY; ex_ra = ERA;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_ex_count", ex_count, 0);
    chk("reset_wb_ready", wb_ready, 1);
    chk("reset_flush", flush, 0);

    // back-to-back normal commits, csr write on the second
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 1'b0, i == 1, 32'h1c000000 + 32'(i * 4), 32'h0);
      #1;
      chk("b2b_wb_ready", wb_ready, 1);
      chk("b2b_retire", retire, 1);
      chk("b2b_csr_we", csr_we, (i == 1));
      chk("b2b_wb_ex", wb_ex, 0);
      chk("b2b_flush", flush, 0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("b2b_ex_count", ex_count, 0);

    // SYS with redirect_ready held low for 3 cycles; WB keeps presenting
    @(negedge clk);
    drive(1'b0, 6'h04, 1'b0, 1'b0, 32'h1c000010, 32'h0);
    #1;
    chk("sys_wb_ex", wb_ex, 1);
    chk("sys_ecode", wb_ecode, 6'hB);
    chk("sys_flush_commit", flush, 1);
    exp_cnt = exp_cnt + 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 1'b1, 1'b1, 32'h1c000014, 32'h0);
      redirect_ready = (c == 3);
      #1;
      chk("sys_redirect_valid", redirect_valid, 1);
      chk("sys_redirect_pc", redirect_pc, ENTRY);
      chk("sys_wb_ready", wb_ready, 0);
      chk("sys_flush_hold", flush, 1);
      chk("sys_no_csr_we", csr_we, 0);
      chk("sys_no_ertn", ertn_flush, 0);
      chk("sys_no_retire", retire, 0);
      chk("sys_ex_count", ex_count, exp_cnt);
    end
    @(negedge clk);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 32'h1c008000, 32'h0);
    redirect_ready = 1'b0;
    #1;
    chk("sys_after_valid", redirect_valid, 0);
    chk("sys_after_ready", wb_ready, 1);
    chk("sys_after_retire", retire, 1);
    @(negedge clk);
    idle_inputs();

    // table-driven vectors, each from IDLE
    for (int i = 0; i < 13; i++) begin
      pc = 32'h1c001000 + 32'(i * 16);
      va = 32'h00800000 + 32'(i * 3);
      @(negedge clk);
      drive(vecs[i].has_int, vecs[i].flags, vecs[i].ertn, vecs[i].cwe, pc, va);
      #1;
      chk("vec_wb_ready", wb_ready, 1);
      chk("vec_wb_ex", wb_ex, vecs[i].ex);
      chk("vec_ecode", wb_ecode, vecs[i].ecode);
      chk("vec_esub", wb_esubcode, vecs[i].esub);
      chk("vec_csr_we", csr_we, vecs[i].o_cwe);
      chk("vec_ertn_flush", ertn_flush, vecs[i].o_ertn);
      chk("vec_retire", retire, vecs[i].o_ret);
      chk("vec_flush", flush, vecs[i].ex | vecs[i].o_ertn);
      chk("vec_csr_wb_pc", csr_wb_pc, pc);
      chk("vec_csr_wb_vaddr", csr_wb_vaddr, va);
      chk("vec_csr_wnum", csr_wnum, pc[13:0] ^ 14'h0155);
      chk("vec_csr_wvalue", csr_wvalue, va ^ 32'h5a5a5a5a);
      if (vecs[i].ex) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      idle_inputs();
      if (vecs[i].ex || vecs[i].o_ertn) begin
        rpc = vecs[i].ex ? ENTRY : ERA;
        redirect_ready = 1'b1;
        #1;
        chk("vec_redirect_valid", redirect_valid, 1);
        chk("vec_redirect_pc", redirect_pc, rpc);
        chk("vec_redirect_flush", flush, 1);
        chk("vec_redirect_ertn_once", ertn_flush, 0);
        @(negedge clk);
        redirect_ready = 1'b0;
      end
      #1;
      chk("vec_idle_valid", redirect_valid, 0);
      chk("vec_idle_ready", wb_ready, 1);
      chk("vec_ex_count", ex_count, exp_cnt);
    end

    // counter wrap: 16 exceptions with redirect_ready tied high
    redirect_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive(1'b0, 6'h08, 1'b0, 1'b0, 32'h1c002000, 32'h0);
      #1;
      chk("wrap_wb_ex", wb_ex, 1);
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      chk("wrap_redirect_valid", redirect_valid, 1);
      chk("wrap_ex_count", ex_count, exp_cnt);
      @(negedge clk);
      #1;
      chk("wrap_back_idle", wb_ready, 1);
    end
    idle_inputs();

    // reset while REDIRECT is pending
    @(negedge clk);
    drive(1'b0, 6'h04, 1'b0, 1'b0, 32'h1c003000, 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst_pre_redirect_valid", redirect_valid, 1);
    chk("rst_pre_ex_count_nonzero", ex_count != '0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_ex_count", ex_count, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
